// File: rtl/fir_vec_sequencer_pkg.sv
// Shared definitions for the FIR vector sequencer: ALU opcodes and sequencer states.
package fir_vec_sequencer_pkg;

  localparam logic [2:0] VADD = 3'b000;
  localparam logic [2:0] VMUL = 3'b011;
  localparam logic [2:0] VROT = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MUL   = 3'd2,
    ADD   = 3'd3,
    ROT   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fir_vec_sequencer_tap_counter.sv
// Tap index k for the FIR sequencer; flags the final tap so the FSM can exit after ROT.
module fir_tap_counter
  import fir_vec_sequencer_pkg::*;
#(
  parameter int TAPS_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [TAPS_W-1:0] n,
  output logic              last
);

  logic [TAPS_W-1:0] k;
  logic [TAPS_W:0]   k_inc;

  // One extra bit keeps k + 1 from wrapping when N is at its maximum.
  assign k_inc = {1'b0, k} + (TAPS_W + 1)'(1);
  assign last  = (k_inc >= {1'b0, n});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (clr) begin
      k <= '0;
    end else if (en) begin
      k <= k_inc[TAPS_W-1:0];
    end
  end

endmodule

// File: rtl/fir_vec_sequencer.sv
// Sequences clear -> (multiply, accumulate, rotate) x N on the vector ALU and register file.
module fir_vec_sequencer
  import fir_vec_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int TAPS_W   = 5,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TAPS_W-1:0] taps,
  input  logic [ADDR_W-1:0] samp_addr,
  input  logic [ADDR_W-1:0] coef_base,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [ADDR_W-1:0] tmp_addr,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [2:0]        alu_ctrl,
  output logic              reg_file_sel,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  state_t            state, state_nxt;
  logic [TAPS_W-1:0] taps_q, taps_n;
  logic [ADDR_W-1:0] samp_q, coef_q, acc_q, tmp_q;
  logic [ADDR_W-1:0] samp_n, coef_n, acc_n, tmp_n;
  logic              wr_en_q;
  logic              accept;
  logic              tap_step;
  logic              last_tap;

  assign accept   = (state == IDLE) && start;
  assign tap_step = (state == ROT) && !hold;

  fir_tap_counter #(
    .TAPS_W(TAPS_W)
  ) u_tap_counter (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (tap_step),
    .n   (taps_q),
    .last(last_tap)
  );

  // coef_q tracks coef_base + k directly so the MUL read address needs no adder on k.
  always_comb begin
    state_nxt = state;
    taps_n    = taps_q;
    samp_n    = samp_q;
    coef_n    = coef_q;
    acc_n     = acc_q;
    tmp_n     = tmp_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          taps_n    = taps;
          samp_n    = samp_addr;
          coef_n    = coef_base;
          acc_n     = acc_addr;
          tmp_n     = tmp_addr;
        end
      end
      CLEAR: if (!hold) state_nxt = (taps_q == '0) ? DONE : MUL;
      MUL:   if (!hold) state_nxt = ADD;
      ADD:   if (!hold) state_nxt = ROT;
      ROT: begin
        if (!hold) begin
          state_nxt = last_tap ? DONE : MUL;
          coef_n    = coef_q + ADDR_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      taps_q       <= '0;
      samp_q       <= '0;
      coef_q       <= '0;
      acc_q        <= '0;
      tmp_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      alu_ctrl     <= VADD;
      reg_file_sel <= 1'b0;
      rd_a_addr    <= '0;
      rd_b_addr    <= '0;
      wr_addr      <= '0;
      wr_en_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      taps_q       <= taps_n;
      samp_q       <= samp_n;
      coef_q       <= coef_n;
      acc_q        <= acc_n;
      tmp_q        <= tmp_n;
      busy         <= 1'b0;
      done         <= 1'b0;
      alu_ctrl     <= VADD;
      reg_file_sel <= 1'b0;
      rd_a_addr    <= '0;
      rd_b_addr    <= '0;
      wr_addr      <= '0;
      wr_en_q      <= 1'b0;
      case (state_nxt)
        CLEAR: begin
          busy         <= 1'b1;
          reg_file_sel <= 1'b1;
          alu_ctrl     <= VADD;
          rd_a_addr    <= ZERO_ADDR;
          rd_b_addr    <= ZERO_ADDR;
          wr_addr      <= acc_n;
          wr_en_q      <= 1'b1;
        end
        MUL: begin
          busy         <= 1'b1;
          reg_file_sel <= 1'b1;
          alu_ctrl     <= VMUL;
          rd_a_addr    <= samp_n;
          rd_b_addr    <= coef_n;
          wr_addr      <= tmp_n;
          wr_en_q      <= 1'b1;
        end
        ADD: begin
          busy         <= 1'b1;
          reg_file_sel <= 1'b1;
          alu_ctrl     <= VADD;
          rd_a_addr    <= acc_n;
          rd_b_addr    <= tmp_n;
          wr_addr      <= acc_n;
          wr_en_q      <= 1'b1;
        end
        ROT: begin
          busy         <= 1'b1;
          reg_file_sel <= 1'b1;
          alu_ctrl     <= VROT;
          rd_a_addr    <= samp_n;
          rd_b_addr    <= samp_n;
          wr_addr      <= samp_n;
          wr_en_q      <= 1'b1;
        end
        DONE: begin
          reg_file_sel <= 1'b1;
          done         <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // A stall must never commit a write, so the strobe is gated combinationally.
  assign wr_en = wr_en_q & ~hold;

endmodule

// File: tb/tb_fir_vec_sequencer.sv
// Directed bench for fir_vec_sequencer: cycle-by-cycle output checks with hand-derived vectors.
module tb_fir_vec_sequencer;
  import fir_vec_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] taps = '0;
  logic [3:0] samp_addr = '0, coef_base = '0, acc_addr = '0, tmp_addr = '0;
  logic       hold = 1'b0;
  logic       busy, done, reg_file_sel, wr_en;
  logic [2:0] alu_ctrl;
  logic [3:0] rd_a_addr, rd_b_addr, wr_addr;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int w0, d0;

  fir_vec_sequencer #(.ADDR_W(4), .TAPS_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .start(start), .taps(taps),
    .samp_addr(samp_addr), .coef_base(coef_base), .acc_addr(acc_addr), .tmp_addr(tmp_addr),
    .hold(hold), .busy(busy), .done(done), .alu_ctrl(alu_ctrl), .reg_file_sel(reg_file_sel),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .wr_addr(wr_addr), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Packed view: {alu, sel, rd_a, rd_b, wr, wr_en, busy, done}
  function automatic logic [18:0] pk(input logic [2:0] alu, input logic sel,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [3:0] wa, input logic we,
                                     input logic bz, input logic dn);
    return {alu, sel, ra, rb, wa, we, bz, dn};
  endfunction

  function automatic logic [18:0] outs();
    return pk(alu_ctrl, reg_file_sel, rd_a_addr, rd_b_addr, wr_addr, wr_en, busy, done);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input logic [4:0] n, input logic [3:0] s, input logic [3:0] c,
                    input logic [3:0] a, input logic [3:0] t);
    start = 1'b1; taps = n; samp_addr = s; coef_base = c; acc_addr = a; tmp_addr = t;
  endtask

  task automatic run_expect(input string tag, input logic [4:0] n, input logic [3:0] s,
                            input logic [3:0] c, input logic [3:0] a, input logic [3:0] t);
    logic [3:0] cj;
    go(n, s, c, a, t);
    tick();
    start = 1'b0;
    chk({tag, "_clear"}, outs(), pk(VADD, 1'b1, 4'd0, 4'd0, a, 1'b1, 1'b1, 1'b0));
    for (int j = 0; j < int'(n); j++) begin
      cj = c + 4'(j);
      tick();
      chk($sformatf("%s_mul%0d", tag, j), outs(), pk(VMUL, 1'b1, s, cj, t, 1'b1, 1'b1, 1'b0));
      tick();
      chk($sformatf("%s_add%0d", tag, j), outs(), pk(VADD, 1'b1, a, t, a, 1'b1, 1'b1, 1'b0));
      tick();
      chk($sformatf("%s_rot%0d", tag, j), outs(), pk(VROT, 1'b1, s, s, s, 1'b1, 1'b1, 1'b0));
    end
    tick();
    chk({tag, "_done"}, outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk({tag, "_idle"}, outs(), pk(VADD, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_hold", outs(), 19'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rst_idle", outs(), 19'd0);

    // N=3 baseline: coef 8, 9, 10; done 11 edges after start; 10 writes
    w0 = wr_cnt; d0 = done_cnt;
    run_expect("n3", 5'd3, 4'd2, 4'd8, 4'd4, 4'd5);
    chk("n3_wr_count", wr_cnt - w0, 10);
    chk("n3_done_count", done_cnt - d0, 1);

    // N=0: only the clear write, done two edges after start
    w0 = wr_cnt;
    go(5'd0, 4'd2, 4'd8, 4'd4, 4'd5);
    tick();
    start = 1'b0;
    chk("n0_clear", outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0));
    tick();
    chk("n0_done", outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("n0_idle", outs(), 19'd0);
    chk("n0_wr_count", wr_cnt - w0, 1);

    // N=2, two hold cycles in the second ADD: done at edge 10 instead of 8
    w0 = wr_cnt;
    go(5'd2, 4'd2, 4'd8, 4'd4, 4'd5);
    tick();
    start = 1'b0;
    chk("hd_clear", outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_mul0", outs(), pk(VMUL, 1'b1, 4'd2, 4'd8, 4'd5, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_add0", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_rot0", outs(), pk(VROT, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_mul1", outs(), pk(VMUL, 1'b1, 4'd2, 4'd9, 4'd5, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_add1", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b1, 1'b1, 1'b0));
    hold = 1'b1;
    #1;
    chk("hd_gate", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b0, 1'b1, 1'b0));
    tick();
    chk("hd_stall1", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b0, 1'b1, 1'b0));
    tick();
    chk("hd_stall2", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b0, 1'b1, 1'b0));
    hold = 1'b0;
    #1;
    chk("hd_release", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_rot1", outs(), pk(VROT, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0));
    tick();
    chk("hd_done", outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("hd_idle", outs(), 19'd0);
    chk("hd_wr_count", wr_cnt - w0, 7);

    // coef_base=15, N=2: second MUL reads register 0
    run_expect("wrap", 5'd2, 4'd3, 4'd15, 4'd6, 4'd7);

    // start pulsed mid-run is ignored
    d0 = done_cnt;
    go(5'd1, 4'd2, 4'd8, 4'd4, 4'd5);
    tick();
    start = 1'b0;
    chk("rs_clear", outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0));
    tick();
    chk("rs_mul", outs(), pk(VMUL, 1'b1, 4'd2, 4'd8, 4'd5, 1'b1, 1'b1, 1'b0));
    go(5'd7, 4'd9, 4'd1, 4'd11, 4'd12);
    tick();
    start = 1'b0;
    chk("rs_add", outs(), pk(VADD, 1'b1, 4'd4, 4'd5, 4'd4, 1'b1, 1'b1, 1'b0));
    tick();
    chk("rs_rot", outs(), pk(VROT, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0));
    tick();
    chk("rs_done", outs(), pk(VADD, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("rs_idle", outs(), 19'd0);
    tick();
    chk("rs_no_restart", outs(), 19'd0);
    chk("rs_done_count", done_cnt - d0, 1);

    // Reset during ROT with N=5, then a fresh run
    go(5'd5, 4'd2, 4'd8, 4'd4, 4'd5);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_rot", outs(), pk(VROT, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1, 1'b0));
    rst = 1'b1;
    #1;
    chk("mr_async", outs(), 19'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mr_idle", outs(), 19'd0);
    run_expect("mr_fresh", 5'd2, 4'd1, 4'd3, 4'd6, 4'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
